ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter and sequencer for the synth's single-port sample/patch RAM. It accepts independent read/write requests from two masters, for example the voice engine and the host loader. It grants them round-robin and drives the RAM's address, read/write and write-data lines. It captures registered read data and returns it to the winning requester with a one-cycle acknowledge pulse.

## Interface
- ADDR_WIDTH, 16, RAM address width
- DATA_WIDTH, 8, RAM data width
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- Req0 / Req1  in  1  access request; held high until matching Ack
- Write0 / Write1  in  1  1 = write, 0 = read; stable while Req high
- Addr0 / Addr1  in  ADDR_WIDTH  access address; stable while Req high
- WData0 / WData1  in  DATA_WIDTH  write data; stable while Req high
- RData0 / RData1  out  DATA_WIDTH  read result; valid when Ack high, held until next read completes for that port
- Ack0 / Ack1  out  1  one-cycle completion pulse
- Busy  out  1  high whenever state is not IDLE
- RamAddress  out  ADDR_WIDTH  RAM address
- RamReadWrite  out  1  1 = write, 0 = read; matches RAM convention
- RamWData  out  DATA_WIDTH  data driven to RAM on write
- RamRData  in  DATA_WIDTH  RAM registered read data, valid one edge after a read is sampled

## Operation
- States: IDLE, ACCESS, COMPLETE.
- IDLE: evaluate eligible requests and go to ACCESS if any exist. Eligible means Reqn is high and Ackn is not high this cycle; this suppresses a duplicate grant while the requester is still dropping Req.
- Arbitration: single request wins outright. If both request, the port not in LastGrant wins; LastGrant then updates to the winner.
- On grant: register Grant (port index), RamAddress ← Addrn, RamWData ← WDatan, RamReadWrite ← Writen.
- ACCESS: the RAM samples address and RW at the end-of-state edge. Next state is COMPLETE.
- COMPLETE: RamReadWrite ← 0. For a read, RDatan ← RamRData at the end-of-state edge. Ackn ← 1 for the following cycle, and next state is IDLE.
- RamReadWrite is high only during ACCESS of a write. In all other states it is 0. RamAddress holds its last value.
- A write never modifies RDatan. The non-granted port's outputs are unchanged.
- The requester must not change Write/Addr/WData while Req is high. Dropping Req before Ack is illegal and does not cancel an access already granted.

## Timing
- Reset values: state IDLE, Ack0 = Ack1 = 0, Busy 0, RamReadWrite 0, RamAddress 0, RamWData 0, RData0 = RData1 = 0, LastGrant = 1 (port 0 wins the first tie).
- Latency: Req sampled high in IDLE at edge E0. ACCESS runs E0–E1 and COMPLETE runs E1–E2. Ack is high E2–E3, so Ack appears 2 edges after the grant edge.
- Throughput: one access per 3 cycles; the IDLE cycle overlaps the previous Ack cycle. With both requesting continuously, grants alternate 0,1,0,1 and each port completes every 6 cycles.
- Simultaneous: requests arriving together are resolved by LastGrant in the same IDLE cycle. No request is ever starved beyond one other access.
- Reset mid-operation: forces IDLE and clears RamReadWrite immediately (asynchronously). A write in ACCESS when Reset asserts before the edge is not performed. No Ack is issued for an aborted access, and the requester must re-request.
- Busy is high from E0 to E2 and low during the Ack cycle.

## Test plan
- Write then read, port 0: write Addr0=0x1234, WData0=0xA5. Ack0 appears at E0+2 and RamReadWrite is high only in ACCESS. Then read 0x1234: RData0 = 0xA5 with Ack0, and RData1 is unchanged.
- Tie after reset: Req0 and Req1 rise together. Port 0 is granted first (Ack0 at E0+2), then port 1 (Ack1 at E0+5).
- Continuous contention: both hold Req and drop it on Ack, for 12 accesses. Acks alternate strictly, no port gets two in a row, and the spacing is 3 cycles.
- Duplicate suppression: requester 0 drops Req one cycle after Ack0. Exactly one access occurs and Busy returns low.
- Reset during ACCESS of a write of 0x5A to 0x0010: no Ack is issued, all outputs take reset values, and a subsequent read of 0x0010 returns the prior contents.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a
// single-port RAM with registered read data. Each access is a grant cycle
// (IDLE), an ACCESS cycle in which the RAM samples address/RW, and a
// COMPLETE cycle that captures read data, followed by a one-cycle Ack.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Req0,
   input  logic                  Req1,
   input  logic                  Write0,
   input  logic                  Write1,
   input  logic [ADDR_WIDTH-1:0] Addr0,
   input  logic [ADDR_WIDTH-1:0] Addr1,
   input  logic [DATA_WIDTH-1:0] WData0,
   input  logic [DATA_WIDTH-1:0] WData1,
   output logic [DATA_WIDTH-1:0] RData0,
   output logic [DATA_WIDTH-1:0] RData1,
   output logic                  Ack0,
   output logic                  Ack1,
   output logic                  Busy,
   output logic [ADDR_WIDTH-1:0] RamAddress,
   output logic                  RamReadWrite,
   output logic [DATA_WIDTH-1:0] RamWData,
   input  logic [DATA_WIDTH-1:0] RamRData
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_COMPLETE} state_t;

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic                  write_q, write_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic                  busy_q, busy_d;
   logic                  ram_rw_q, ram_rw_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

   logic elig0, elig1, winner, win_write;

   // A port still seeing its Ack is not eligible, so a requester that is
   // slow to drop Req does not get a second grant; ties go to the port
   // that did not win last time.
   always_comb begin
      elig0     = Req0 & ~ack0_q;
      elig1     = Req1 & ~ack1_q;
      winner    = (elig0 & elig1) ? ~last_grant_q : elig1;
      win_write = winner ? Write1 : Write0;
   end

   // Next-state and next-output computation for the access sequencer.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      write_d      = write_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      ram_rw_d     = ram_rw_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      case (state_q)
         ST_IDLE: begin
            if (elig0 | elig1) begin
               grant_d      = winner;
               last_grant_d = winner;
               write_d      = win_write;
               ram_rw_d     = win_write;
               ram_addr_d   = winner ? Addr1 : Addr0;
               ram_wdata_d  = winner ? WData1 : WData0;
               state_d      = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // RAM samples address/RW at the edge ending this state.
            ram_rw_d = 1'b0;
            state_d  = ST_COMPLETE;
         end
         ST_COMPLETE: begin
            // Registered RAM read data is valid now; writes leave RData alone.
            if (!write_q) begin
               if (grant_q) rdata1_d = RamRData;
               else         rdata0_d = RamRData;
            end
            ack0_d  = ~grant_q;
            ack1_d  = grant_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any access in flight and
   // drops the RAM write strobe immediately.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         write_q      <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
         ram_rw_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         write_q      <= write_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         busy_q       <= busy_d;
         ram_rw_q     <= ram_rw_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign RData0       = rdata0_q;
   assign RData1       = rdata1_q;
   assign Ack0         = ack0_q;
   assign Ack1         = ack1_q;
   assign Busy         = busy_q;
   assign RamAddress   = ram_addr_q;
   assign RamReadWrite = ram_rw_q;
   assign RamWData     = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural
// registered-read RAM attached to the RAM port.
module tb_ram_arbiter;
   localparam int AW = 16;
   localparam int DW = 8;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Req0, Req1, Write0, Write1;
   logic [AW-1:0] Addr0, Addr1;
   logic [DW-1:0] WData0, WData1, RData0, RData1;
   logic          Ack0, Ack1, Busy;
   logic [AW-1:0] RamAddress;
   logic          RamReadWrite;
   logic [DW-1:0] RamWData, RamRData;

   logic [DW-1:0] mem [0:65535];
   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   typedef struct {
      int            port;
      bit            rd;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;
   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [DW-1:0] shadow0, shadow1;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .Clock(Clock), .Reset(Reset),
      .Req0(Req0), .Req1(Req1), .Write0(Write0), .Write1(Write1),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .RData0(RData0), .RData1(RData1), .Ack0(Ack0), .Ack1(Ack1), .Busy(Busy),
      .RamAddress(RamAddress), .RamReadWrite(RamReadWrite),
      .RamWData(RamWData), .RamRData(RamRData)
   );

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   initial forever #5 Clock = ~Clock;
   initial forever begin
      @(posedge Clock);
      cyc++;
   end

   // RAM model: write on RW high, registered read data one edge later.
   initial begin
      RamRData = '0;
      for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
      forever begin
         @(posedge Clock);
         if (RamReadWrite === 1'b1) mem[RamAddress] = RamWData;
         RamRData <= mem[RamAddress];
      end
   end

   // Scoreboard: every Ack pops one expected completion.
   initial forever begin
      @(negedge Clock);
      if (Reset !== 1'b0) begin
         shadow0 = '0;
         shadow1 = '0;
      end else if (Ack0 === 1'b1 || Ack1 === 1'b1) begin
         checks++;
         if (Ack0 === 1'b1 && Ack1 === 1'b1)
            $display("FAIL both_acks cyc=%0d", cyc);
         else if (exp_q.size() == 0)
            $display("FAIL unexpected_ack port=%0d cyc=%0d", Ack1, cyc);
         else begin
            mon_e = exp_q.pop_front();
            if (mon_e.rd) begin
               if (mon_e.port == 0) shadow0 = mon_e.data;
               else                 shadow1 = mon_e.data;
            end
            if (int'(Ack1) !== mon_e.port || cyc !== mon_e.cyc ||
                RData0 !== shadow0 || RData1 !== shadow1)
               $display("FAIL scoreboard got port=%0d cyc=%0d rd0=%h rd1=%h want port=%0d cyc=%0d rd0=%h rd1=%h",
                        Ack1, cyc, RData0, RData1, mon_e.port, mon_e.cyc, shadow0, shadow1);
            else passes++;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic wait_ack(input int port, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge Clock);
         if ((port == 0 && Ack0 === 1'b1) || (port == 1 && Ack1 === 1'b1)) ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Req0 = 0; Req1 = 0; Write0 = 0; Write1 = 0;
      Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
      repeat (3) @(negedge Clock);
      checks++;
      if ({Ack0, Ack1, Busy, RamReadWrite} !== 4'b0000)
         $display("FAIL reset_ctrl got %b want 0000", {Ack0, Ack1, Busy, RamReadWrite});
      else passes++;
      checks++;
      if (RamAddress !== '0 || RamWData !== '0)
         $display("FAIL reset_ram got addr=%h wdata=%h want 0/0", RamAddress, RamWData);
      else passes++;
      checks++;
      if (RData0 !== '0 || RData1 !== '0)
         $display("FAIL reset_rdata got %h/%h want 0/0", RData0, RData1);
      else passes++;
      Reset = 1'b0;
   endtask

   task automatic test_write_read();
      int c;
      bit ok;
      @(negedge Clock);
      c = cyc;
      Write0 = 1; Addr0 = 16'h1234; WData0 = 8'hA5; Req0 = 1;
      exp_q.push_back('{0, 1'b0, 8'h00, c + 3});
      for (int k = 1; k <= 3; k++) begin
         @(negedge Clock);
         checks++;
         if (RamReadWrite !== 1'(k == 1) || Busy !== 1'(k < 3) || Ack0 !== 1'(k == 3))
            $display("FAIL write_seq k=%0d got rw=%b busy=%b ack0=%b want %b/%b/%b",
                     k, RamReadWrite, Busy, Ack0, k == 1, k < 3, k == 3);
         else passes++;
      end
      Req0 = 0;
      checks++;
      if (RamAddress !== 16'h1234 || RamWData !== 8'hA5 || mem[16'h1234] !== 8'hA5)
         $display("FAIL write_ram got addr=%h wdata=%h mem=%h want 1234/a5/a5",
                  RamAddress, RamWData, mem[16'h1234]);
      else passes++;
      @(negedge Clock);
      c = cyc;
      Write0 = 0; Req0 = 1;
      exp_q.push_back('{0, 1'b1, 8'hA5, c + 3});
      wait_ack(0, 10, ok);
      Req0 = 0;
      checks++;
      if (!ok || RData0 !== 8'hA5 || RData1 !== 8'h00)
         $display("FAIL read_back got ack=%b rd0=%h rd1=%h want 1/a5/00", ok, RData0, RData1);
      else passes++;
   endtask

   task automatic test_tie();
      int c;
      bit ok0, ok1;
      do_reset();
      c = cyc;
      Write0 = 0; Write1 = 0; Addr0 = 16'h0300; Addr1 = 16'h0301;
      Req0 = 1; Req1 = 1;
      exp_q.push_back('{0, 1'b1, pat(16'h0300), c + 3});
      exp_q.push_back('{1, 1'b1, pat(16'h0301), c + 6});
      fork
         begin wait_ack(0, 10, ok0); Req0 = 0; end
         begin wait_ack(1, 15, ok1); Req1 = 0; end
      join
      checks++;
      if (!ok0 || !ok1) $display("FAIL tie_timeout got ack0=%b ack1=%b want 1/1", ok0, ok1);
      else passes++;
   endtask

   task automatic test_contention();
      int c;
      int miss0, miss1;
      miss0 = 0; miss1 = 0;
      @(negedge Clock);
      do_reset();
      c = cyc;
      for (int k = 0; k < 12; k++) begin
         logic [AW-1:0] a;
         a = (k % 2 == 1) ? 16'(16'h0200 + k / 2) : 16'(16'h0100 + k / 2);
         exp_q.push_back('{k % 2, 1'b1, pat(a), c + 3 + 3 * k});
      end
      fork
         begin
            for (int n = 0; n < 6; n++) begin
               bit ok;
               Addr0 = 16'(16'h0100 + n); Write0 = 0; Req0 = 1;
               wait_ack(0, 12, ok);
               if (!ok) miss0++;
               Req0 = 0;
               @(negedge Clock);
            end
         end
         begin
            for (int n = 0; n < 6; n++) begin
               bit ok;
               Addr1 = 16'(16'h0200 + n); Write1 = 0; Req1 = 1;
               wait_ack(1, 12, ok);
               if (!ok) miss1++;
               Req1 = 0;
               @(negedge Clock);
            end
         end
      join
      checks++;
      if (miss0 != 0 || miss1 != 0)
         $display("FAIL contention_timeout got miss0=%0d miss1=%0d want 0/0", miss0, miss1);
      else passes++;
   endtask

   task automatic test_dup();
      int c;
      bit ok;
      @(negedge Clock);
      c = cyc;
      Addr0 = 16'h0042; Write0 = 0; Req0 = 1;
      exp_q.push_back('{0, 1'b1, pat(16'h0042), c + 3});
      wait_ack(0, 10, ok);
      checks++;
      if (!ok) $display("FAIL dup_timeout got ack=0 want 1");
      else passes++;
      @(negedge Clock);
      Req0 = 0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (Busy !== 1'b0 || Ack0 !== 1'b0)
            $display("FAIL dup_idle k=%0d got busy=%b ack0=%b want 0/0", k, Busy, Ack0);
         else passes++;
         @(negedge Clock);
      end
   endtask

   task automatic test_reset_access();
      int c;
      bit ok;
      @(negedge Clock);
      Write0 = 1; Addr0 = 16'h0010; WData0 = 8'h5A; Req0 = 1;
      @(negedge Clock);
      checks++;
      if (RamReadWrite !== 1'b1 || Busy !== 1'b1)
         $display("FAIL abort_access got rw=%b busy=%b want 1/1", RamReadWrite, Busy);
      else passes++;
      #1 Reset = 1'b1;
      #1;
      checks++;
      if (RamReadWrite !== 1'b0 || Busy !== 1'b0 || Ack0 !== 1'b0 || Ack1 !== 1'b0 ||
          RamAddress !== '0 || RamWData !== '0 || RData0 !== '0 || RData1 !== '0)
         $display("FAIL abort_outputs got rw=%b busy=%b ack=%b%b addr=%h wd=%h rd=%h/%h want all 0",
                  RamReadWrite, Busy, Ack0, Ack1, RamAddress, RamWData, RData0, RData1);
      else passes++;
      Req0 = 0; Write0 = 0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      checks++;
      if (mem[16'h0010] !== pat(16'h0010))
         $display("FAIL abort_mem got %h want %h", mem[16'h0010], pat(16'h0010));
      else passes++;
      repeat (3) @(negedge Clock);
      c = cyc;
      Req0 = 1;
      exp_q.push_back('{0, 1'b1, pat(16'h0010), c + 3});
      wait_ack(0, 10, ok);
      Req0 = 0;
      checks++;
      if (!ok || RData0 !== pat(16'h0010))
         $display("FAIL abort_readback got ack=%b rd0=%h want 1/%h", ok, RData0, pat(16'h0010));
      else passes++;
   endtask

   initial begin
      Reset = 1'b1;
      test_reset();
      test_write_read();
      test_tie();
      test_contention();
      test_dup();
      test_reset_access();
      repeat (4) @(negedge Clock);
      checks++;
      if (exp_q.size() != 0) $display("FAIL pending_acks got %0d want 0", exp_q.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
